// File: rtl/free_recorder.sv
// Free-play capture engine: run-length encodes the held note into (note, duration)
// entries and replays them over a valid/ready stream.
module free_recorder #(
   parameter int unsigned DEPTH     = 32,
   parameter int unsigned DUR_WIDTH = 8,
   parameter int unsigned TICK_DIV  = 5_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [3:0]               user_input,
   input  logic                     higher_8,
   input  logic                     record_en,
   input  logic                     rd_start,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [4:0]               rd_note,
   output logic [DUR_WIDTH-1:0]     rd_dur,
   output logic                     rd_done,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     recording
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TICK_DIV + 1);
   localparam int unsigned EW = 5 + DUR_WIDTH;
   localparam logic [DUR_WIDTH-1:0] DUR_MAX   = '1;
   localparam logic [TW-1:0]        TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [CW-1:0]        LAST_SLOT = CW'(DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_REC, S_READ} state_t;

   state_t                 r_state;
   logic [4:0]             r_cur_note;
   logic                   r_rec_sync;
   logic                   r_rec_prev;
   logic [4:0]             r_seg_note;
   logic [DUR_WIDTH-1:0]   r_seg_dur;
   logic [TW-1:0]          r_tick;
   logic [CW-1:0]          r_count;
   logic                   r_full;
   logic                   r_recording;
   logic [AW-1:0]          r_rd_ptr;
   logic                   r_rd_valid;
   logic                   r_rd_done;
   logic [4:0]             r_rd_note;
   logic [DUR_WIDTH-1:0]   r_rd_dur;
   logic [EW-1:0]          r_mem [DEPTH];

   logic [4:0]             w_note_in;
   logic                   w_rec_rise;
   logic                   w_close;
   logic                   w_wr_en;
   logic [AW-1:0]          w_rd_addr;
   logic [EW-1:0]          w_rd_word;
   logic                   w_rd_last;

   assign w_note_in  = (user_input == 4'd0) ? 5'd0 : {higher_8, user_input};
   assign w_rec_rise = r_rec_sync & ~r_rec_prev;
   assign w_close    = (r_cur_note != r_seg_note) || (r_seg_dur == DUR_MAX);
   // Any close or the end of the session writes, but zero-tick segments are glitches.
   assign w_wr_en    = (r_state == S_REC) && (r_seg_dur != '0) && (!r_rec_sync || w_close);
   assign w_rd_addr  = (r_state == S_IDLE) ? '0 : r_rd_ptr;
   assign w_rd_word  = r_mem[w_rd_addr];
   assign w_rd_last  = ({1'b0, r_rd_ptr} == (r_count - CW'(1)));

   always_ff @(posedge clk) begin
      if (!rst && w_wr_en)
         r_mem[r_count[AW-1:0]] <= {r_seg_note, r_seg_dur};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cur_note  <= '0;
         r_rec_sync  <= 1'b0;
         r_rec_prev  <= 1'b0;
         r_seg_note  <= '0;
         r_seg_dur   <= '0;
         r_tick      <= '0;
         r_count     <= '0;
         r_full      <= 1'b0;
         r_recording <= 1'b0;
         r_rd_ptr    <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_done   <= 1'b0;
         r_rd_note   <= '0;
         r_rd_dur    <= '0;
      end else begin
         r_cur_note <= w_note_in;
         r_rec_sync <= record_en;
         r_rec_prev <= r_rec_sync;
         r_rd_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_rec_rise) begin
                  r_state     <= S_REC;
                  r_count     <= '0;
                  r_full      <= 1'b0;
                  r_seg_note  <= r_cur_note;
                  r_seg_dur   <= '0;
                  r_tick      <= '0;
                  r_recording <= 1'b1;
               end else if (rd_start) begin
                  if (r_count != '0) begin
                     r_state    <= S_READ;
                     r_rd_ptr   <= '0;
                     r_rd_valid <= 1'b1;
                     r_rd_note  <= w_rd_word[EW-1:DUR_WIDTH];
                     r_rd_dur   <= w_rd_word[DUR_WIDTH-1:0];
                  end else begin
                     r_rd_done <= 1'b1;
                  end
               end
            end
            S_REC: begin
               if (w_wr_en)
                  r_count <= r_count + CW'(1);
               if (w_wr_en && (r_count == LAST_SLOT)) begin
                  r_full      <= 1'b1;
                  r_state     <= S_IDLE;
                  r_recording <= 1'b0;
               end else if (!r_rec_sync) begin
                  r_state     <= S_IDLE;
                  r_recording <= 1'b0;
               end else if (w_close) begin
                  r_seg_note <= r_cur_note;
                  r_seg_dur  <= '0;
                  r_tick     <= '0;
               end else if (r_tick == TICK_LAST) begin
                  r_tick    <= '0;
                  r_seg_dur <= r_seg_dur + DUR_WIDTH'(1);
               end else begin
                  r_tick <= r_tick + TW'(1);
               end
            end
            S_READ: begin
               // After each accept, one bubble cycle fetches the next entry.
               if (r_rd_valid) begin
                  if (rd_ready) begin
                     r_rd_valid <= 1'b0;
                     if (w_rd_last) begin
                        r_rd_done <= 1'b1;
                        r_state   <= S_IDLE;
                     end else begin
                        r_rd_ptr <= r_rd_ptr + AW'(1);
                     end
                  end
               end else begin
                  r_rd_valid <= 1'b1;
                  r_rd_note  <= w_rd_word[EW-1:DUR_WIDTH];
                  r_rd_dur   <= w_rd_word[DUR_WIDTH-1:0];
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rd_valid  = r_rd_valid;
   assign rd_note   = r_rd_note;
   assign rd_dur    = r_rd_dur;
   assign rd_done   = r_rd_done;
   assign count     = r_count;
   assign full      = r_full;
   assign recording = r_recording;

endmodule

// File: tb/tb_free_recorder.sv
// Bench for free_recorder: cycle model built from segment lengths in elapsed cycles,
// directed scenarios with literal expectations, then randomized sessions.
module tb_free_recorder;
   localparam int TD   = 4;
   localparam int DP   = 4;
   localparam int DW   = 4;
   localparam int DMAX = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  user_input;
   logic        higher_8, record_en, rd_start, rd_ready;
   logic        rd_valid, rd_done, full, recording;
   logic [4:0]  rd_note;
   logic [DW-1:0] rd_dur;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_err = 0;

   free_recorder #(.DEPTH(DP), .DUR_WIDTH(DW), .TICK_DIV(TD)) dut (
      .clk(clk), .rst(rst), .user_input(user_input), .higher_8(higher_8),
      .record_en(record_en), .rd_start(rd_start), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_note(rd_note), .rd_dur(rd_dur), .rd_done(rd_done),
      .count(count), .full(full), .recording(recording)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a segment's duration is its elapsed matching cycles / TD.
   int  m_mode;
   int  seen_note, seen_en, prev_en;
   int  seg_note, seg_cyc, m_ptr, m_d;
   int  e_valid, e_done, e_count, e_full, e_rec, e_note, e_dur;
   int  m_note [DP];
   int  m_dur  [DP];
   bit  m_live = 1'b0;
   bit  m_wr;

   always @(posedge clk) begin
      if (rst) begin
         m_live = 1'b1;
         m_mode = 0; seen_note = 0; seen_en = 0; prev_en = 0;
         seg_note = 0; seg_cyc = 0; m_ptr = 0;
         e_valid = 0; e_done = 0; e_count = 0; e_full = 0; e_rec = 0; e_note = 0; e_dur = 0;
      end else begin
         e_done = 0;
         case (m_mode)
            0: begin
               if (seen_en != 0 && prev_en == 0) begin
                  m_mode = 1; e_count = 0; e_full = 0; e_rec = 1;
                  seg_note = seen_note; seg_cyc = 0;
               end else if (rd_start) begin
                  if (e_count > 0) begin
                     m_mode = 2; m_ptr = 0; e_valid = 1;
                     e_note = m_note[0]; e_dur = m_dur[0];
                  end else begin
                     e_done = 1;
                  end
               end
            end
            1: begin
               m_d = seg_cyc / TD;
               if (seen_en == 0 || seen_note != seg_note || m_d == DMAX) begin
                  m_wr = (m_d >= 1);
                  if (m_wr) begin
                     m_note[e_count] = seg_note; m_dur[e_count] = m_d; e_count++;
                  end
                  if (m_wr && e_count == DP) begin
                     e_full = 1; m_mode = 0; e_rec = 0;
                  end else if (seen_en == 0) begin
                     m_mode = 0; e_rec = 0;
                  end else begin
                     seg_note = seen_note; seg_cyc = 0;
                  end
               end else begin
                  seg_cyc++;
               end
            end
            default: begin
               if (e_valid != 0) begin
                  if (rd_ready) begin
                     e_valid = 0;
                     if (m_ptr == e_count - 1) begin
                        e_done = 1; m_mode = 0;
                     end else begin
                        m_ptr++;
                     end
                  end
               end else begin
                  e_valid = 1; e_note = m_note[m_ptr]; e_dur = m_dur[m_ptr];
               end
            end
         endcase
         prev_en   = seen_en;
         seen_en   = int'(record_en);
         seen_note = (user_input == 4'd0) ? 0 : (int'(higher_8) * 16 + int'(user_input));
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("rd_valid", rd_valid, e_valid);
         chk("rd_done", rd_done, e_done);
         chk("count", count, e_count);
         chk("full", full, e_full);
         chk("recording", recording, e_rec);
         if (e_valid != 0) begin
            chk("rd_note", rd_note, e_note);
            chk("rd_dur", rd_dur, e_dur);
         end
      end
   end

   int cap_note [8];
   int cap_dur  [8];
   int n_cap;

   task automatic wait_rec();
      bit seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (recording) seen = 1'b1;
      end
      chk("rec_start_seen", seen, 1);
   endtask

   // mode 0: always ready, 1: random ready, 2: ready low for the first 10 cycles
   task automatic readout(input int mode);
      bit done_seen = 1'b0;
      n_cap = 0;
      rd_start = 1'b1;
      rd_ready = (mode == 0);
      for (int c = 0; c < 300 && !done_seen; c++) begin
         @(negedge clk);
         rd_start = 1'b0;
         if (rd_done) begin
            done_seen = 1'b1;
         end else begin
            case (mode)
               0:       rd_ready = 1'b1;
               1:       rd_ready = 1'($urandom_range(0, 1));
               default: rd_ready = (c >= 10);
            endcase
            if (mode == 2 && c < 10) chk("bp_valid_held", rd_valid, 1);
            if (rd_valid && rd_ready && n_cap < 8) begin
               cap_note[n_cap] = rd_note;
               cap_dur[n_cap]  = rd_dur;
               n_cap++;
            end
         end
      end
      rd_ready = 1'b0;
      chk("rd_done_seen", done_seen, 1);
   endtask

   task automatic end_session();
      record_en = 1'b0;
      repeat (3) @(negedge clk);
      user_input = 4'd0;
      higher_8 = 1'b0;
   endtask

   initial begin
      rst = 1'b1; user_input = 4'd0; higher_8 = 1'b0;
      record_en = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_rec", recording, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic: key 3 for 12 cycles, key 5 up an octave for 8
      user_input = 4'd3; record_en = 1'b1;
      wait_rec();
      repeat (11) @(negedge clk);
      user_input = 4'd5; higher_8 = 1'b1;
      repeat (9) @(negedge clk);
      end_session();
      chk("basic_count", count, 2);
      readout(0);
      chk("basic_n", n_cap, 2);
      chk("basic_e0_note", cap_note[0], 3);
      chk("basic_e0_dur", cap_dur[0], 3);
      chk("basic_e1_note", cap_note[1], 21);
      chk("basic_e1_dur", cap_dur[1], 2);

      // Glitch: 2-cycle key 7 inside a key-1 run
      user_input = 4'd1; record_en = 1'b1;
      wait_rec();
      repeat (10) @(negedge clk);
      user_input = 4'd7;
      repeat (2) @(negedge clk);
      user_input = 4'd1;
      repeat (10) @(negedge clk);
      end_session();
      readout(0);
      chk("glitch_n", n_cap, 2);
      chk("glitch_e0_note", cap_note[0], 1);
      chk("glitch_e0_dur", cap_dur[0], 2);
      chk("glitch_e1_note", cap_note[1], 1);
      chk("glitch_e1_dur", cap_dur[1], 2);

      // Saturation: key 2 for 70 cycles
      user_input = 4'd2; record_en = 1'b1;
      wait_rec();
      repeat (69) @(negedge clk);
      end_session();
      readout(0);
      chk("sat_n", n_cap, 2);
      chk("sat_e0_note", cap_note[0], 2);
      chk("sat_e0_dur", cap_dur[0], 15);
      chk("sat_e1_note", cap_note[1], 2);
      chk("sat_total_ticks", cap_dur[0] + cap_dur[1], 17);

      // Full: five distinct notes of one tick each
      user_input = 4'd1; record_en = 1'b1;
      wait_rec();
      for (int k = 2; k <= 5; k++) begin
         repeat (6) @(negedge clk);
         user_input = 4'(k);
      end
      repeat (6) @(negedge clk);
      chk("full_count", count, 4);
      chk("full_flag", full, 1);
      chk("full_rec_dropped", recording, 0);
      end_session();
      readout(2);
      chk("full_n", n_cap, 4);
      for (int k = 0; k < 4; k++) begin
         chk("full_note", cap_note[k], k + 1);
         chk("full_dur", cap_dur[k], 1);
      end

      // Reset mid-READ, then empty readout
      rd_start = 1'b1;
      @(negedge clk);
      rd_start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_valid", rd_valid, 0);
      chk("midrst_done", rd_done, 0);
      chk("midrst_count", count, 0);
      chk("midrst_full", full, 0);
      chk("midrst_rec", recording, 0);
      chk("midrst_note", rd_note, 0);
      chk("midrst_dur", rd_dur, 0);
      rst = 1'b0;
      @(negedge clk);
      rd_start = 1'b1;
      @(negedge clk);
      rd_start = 1'b0;
      chk("empty_done", rd_done, 1);
      chk("empty_valid", rd_valid, 0);
      @(negedge clk);
      chk("empty_done_pulse", rd_done, 0);
      chk("empty_valid_after", rd_valid, 0);

      // Randomized sessions, checked cycle by cycle against the model
      for (int s = 0; s < 8; s++) begin
         user_input = 4'($urandom_range(0, 15));
         higher_8   = 1'($urandom_range(0, 1));
         record_en  = 1'b1;
         wait_rec();
         for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            user_input = 4'($urandom_range(0, 15));
            higher_8   = 1'($urandom_range(0, 1));
         end
         repeat ($urandom_range(1, 12)) @(negedge clk);
         end_session();
         readout(1);
         repeat (2) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/free_recorder.md
# free_recorder

Capture engine for free-play mode. It samples the note currently held on the switches, run-length encodes it into (note, duration) entries in an internal buffer, and later streams those entries out over a valid/ready handshake. The consumer is the auto-play/playback path, so this block sits on the writer side of song memory. It shares the switch inputs (`user_input`, `higher_8`) with the free-play datapath and does not drive LEDs, segments or the buzzer.

## Interface
- `DEPTH`, 32: number of buffer entries; power of two, 4..256.
- `DUR_WIDTH`, 8: width of the duration field, in ticks.
- `TICK_DIV`, 5_000_000: clock cycles per duration tick (50 ms at 100 MHz).

- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `user_input` in 4: note key 0..15; 0 means no key (rest).
- `higher_8` in 1: octave-up flag; meaningful only when `user_input` != 0.
- `record_en` in 1: level; high = recording session active.
- `rd_start` in 1: one-cycle pulse; starts readout from entry 0.
- `rd_ready` in 1: consumer accepts the current entry.
- `rd_valid` out 1: `rd_note`/`rd_dur` hold a valid entry.
- `rd_note` out 5: {octave, key}; 5'd0 = rest.
- `rd_dur` out DUR_WIDTH: entry duration in ticks, range 1..2^DUR_WIDTH-1.
- `rd_done` out 1: one-cycle pulse after the last entry is accepted.
- `count` out log2(DEPTH)+1: number of entries stored.
- `full` out 1: buffer full; recording has stopped.
- `recording` out 1: high in state REC.

## Operation
- Input register: `cur_note` = (`user_input`==0) ? 0 : {`higher_8`,`user_input`}, registered every cycle. All change detection uses the registered value.
- States:
  - IDLE: holds stored contents.
  - REC: recording session.
  - READ: streaming entries out.
- IDLE -> REC on a `record_en` rising edge (registered edge detect). On entry: `count`←0, `full`←0, `seg_note`←`cur_note`, `seg_dur`←0, tick counter←0.
- In REC, the tick counter counts 0..TICK_DIV-1. At wrap, `seg_dur` increments.
- Segment close, in REC: triggered by `cur_note` != `seg_note`, or by `seg_dur` reaching 2^DUR_WIDTH-1.
  - If `seg_dur` ≥ 1, write {`seg_note`,`seg_dur`} at address `count` and increment `count`.
  - If `seg_dur` = 0, the segment is a glitch filter case: discard it with no write.
  - Then `seg_note`←`cur_note`, `seg_dur`←0, tick counter←0.
  - A saturation close keeps the same note and starts a new segment.
- When `count` reaches DEPTH after a write: `full`←1, go to IDLE. Remaining input is ignored.
- REC -> IDLE on `record_en` low. The open segment is flushed under the same ≥1 rule, unless the buffer is full.
- `record_en` rising while in READ is ignored. Only a fresh rising edge seen in IDLE starts recording.
- IDLE -> READ on `rd_start` when `count` > 0. If `count` = 0, `rd_done` pulses the next cycle and the state stays IDLE.
- READ: `rd_ptr` starts at 0.
  - `rd_valid` = 1 with the entry at `rd_ptr`.
  - When `rd_valid` and `rd_ready` are both high, `rd_ptr` increments.
  - After accepting entry `count`-1: `rd_valid`←0, `rd_done` pulses, go to IDLE.
- `rd_start` during REC or READ is ignored.
- Buffer contents and `count` survive READ, so a recording can be replayed any number of times.

## Timing
- Reset values: state IDLE; `rd_valid`, `rd_done`, `full`, `recording` = 0; `count` = 0; `rd_note`, `rd_dur` = 0; all counters = 0. Buffer RAM is not cleared.
- Reset mid-REC or mid-READ discards the session and returns to IDLE on the next edge.
- Latency, switch change to buffer write: 2 cycles (input register, then compare-and-write). `count` updates on the write edge.
- `recording` goes high 2 cycles after `record_en` rises: one cycle for the sync register, one for edge detect.
- READ entry: `rd_valid` asserts 1 cycle after `rd_start`.
  - A buffer read is 1 cycle (synchronous RAM).
  - With `rd_ready` held high, one entry is accepted every 2 cycles minimum.
- `rd_note`/`rd_dur` stay stable while `rd_valid` is high and `rd_ready` is low.
- A segment close and a saturation on the same cycle produce a single write.
- `rd_done` pulses on the cycle after the final handshake.

## Test plan
- Bench parameters: TICK_DIV=4, DEPTH=4, DUR_WIDTH=4.
- Basic record and readout: hold key 3 for 12 cycles, then key 5 with `higher_8` for 8 cycles, then drop `record_en`. Then `rd_start` with `rd_ready`=1. Required: `count`=2, entries {5'd3,3} and {5'd21,2}, then `rd_done` pulse.
- Glitch filter: key 7 for 2 cycles inside a key-1 run. Required: no entry with note 7; the key-1 run is split into two entries around the glitch.
- Saturation: hold key 2 for 70 cycles. Required: first entry {2,15}, next entry starts at duration 0. Total recorded ticks equals floor of the elapsed ticks.
- Full: 5 alternating notes of 1 tick each. Required: `count`=4, `full`=1, `recording` drops, the 5th note is not stored.
- Backpressure: during READ, hold `rd_ready` low for 10 cycles. Required: `rd_valid` stays high, `rd_note`/`rd_dur` are unchanged, `rd_ptr` does not advance.
- Reset and empty-buffer readout:
  - Assert `rst` mid-READ. Required: all outputs at reset values next cycle.
  - `rd_start` with `count`=0. Required: `rd_done` pulse, `rd_valid` never asserts.
